// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam int DIV_W_DEFAULT = 8;
    localparam int DIV_CNT_W     = $clog2(DIV_W_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left, try subtracting the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_n,
    output logic [W-1:0] quo_n
);

    logic [W:0]   shifted;
    logic [W+1:0] trial;
    logic         unused_trial_bit;

    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        // A non-negative trial is always below the divisor, so it fits in W bits.
        if (!trial[W+1]) begin
            rem_n = trial[W-1:0];
            quo_n = {quo[W-2:0], 1'b1};
        end else begin
            rem_n = shifted[W-1:0];
            quo_n = {quo[W-2:0], 1'b0};
        end
    end

    assign unused_trial_bit = trial[W];

endmodule

// File: rtl/seq_div.sv
// Iterative W-cycle restoring divider with valid/ready on both sides, one operation in flight.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder follows dividend).
module seq_div
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(W);

    div_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q, quo_q, dsr_q;
    logic [W-1:0]     rem_n, quo_n;
    logic [W-1:0]     dvd_mag, dsr_mag;
    logic [W-1:0]     q_fix, r_fix;
    logic [W-1:0]     quotient_q, remainder_q;
    logic             dbz_q;
    logic             accept, last_step, zero_dsr;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_step = (state_q == BUSY) && (cnt_q == '0);
    assign zero_dsr  = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_q, neg_r_q;

    function automatic logic [W-1:0] negate_if(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign dvd_mag = negate_if(dividend, dividend[W-1]);
    assign dsr_mag = negate_if(divisor, divisor[W-1]);
    // The most negative dividend over -1 yields magnitude 2^(W-1), which already reads as -2^(W-1).
    assign q_fix   = negate_if(quo_n, neg_q_q);
    assign r_fix   = negate_if(rem_n, neg_r_q);

    always_ff @(posedge clk) begin
        if (accept) begin
            neg_q_q <= dividend[W-1] ^ divisor[W-1];
            neg_r_q <= dividend[W-1];
        end
    end
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
    assign q_fix   = quo_n;
    assign r_fix   = rem_n;
`endif

    div_step #(.W(W)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dsr_q),
        .rem_n   (rem_n),
        .quo_n   (quo_n)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = zero_dsr ? DONE : BUSY;
            BUSY:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Working registers carry no reset: they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q <= '0;
            quo_q <= dvd_mag;
            dsr_q <= dsr_mag;
            cnt_q <= CNT_W'(W - 1);
        end else if (state_q == BUSY) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept && zero_dsr) begin
            quotient_q  <= '1;
            remainder_q <= dividend;
            dbz_q       <= 1'b1;
        end else if (last_step) begin
            quotient_q  <= q_fix;
            remainder_q <= r_fix;
            dbz_q       <= 1'b0;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (W=8) against an arithmetic reference model.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    seq_div #(.W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operands, signedness depending on build.
    task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic z);
        int sa, sb;
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = 8'(sa / sb);
            r = 8'(sa % sb);
            z = 1'b0;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z,
                         output int lat);
        int g;
        g = 0;
        out_ready = 1'b1;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        while (!in_ready && g < 40) begin
            tick();
            g++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 (op %0d/%0d)", in_ready, a, b);
        end
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        checks += 5;
        if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        if (quotient !== 8'd0)     begin errors++; $display("FAIL rst_quotient: got %0d need 0", quotient); end
        if (remainder !== 8'd0)    begin errors++; $display("FAIL rst_remainder: got %0d need 0", remainder); end
        if (div_by_zero !== 1'b0)  begin errors++; $display("FAIL rst_dbz: got %b need 0", div_by_zero); end
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b, input int want_lat);
        logic [7:0] q, r, eq, er;
        logic z, ez;
        int lat;
        do_op(a, b, q, r, z, lat);
        ref_div(a, b, eq, er, ez);
        checks += 3;
        if (q !== eq) begin errors++; $display("FAIL %s_quotient: %0d/%0d got %0d need %0d", name, a, b, q, eq); end
        if (r !== er) begin errors++; $display("FAIL %s_remainder: %0d/%0d got %0d need %0d", name, a, b, r, er); end
        if (z !== ez) begin errors++; $display("FAIL %s_dbz: %0d/%0d got %b need %b", name, a, b, z, ez); end
        if (want_lat > 0) begin
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL %s_latency: %0d/%0d got %0d cycles need %0d", name, a, b, lat, want_lat);
            end
        end
    endtask

    task automatic test_basic();
        check_op("div200_7", 8'd200, 8'd7, 9);
`ifndef SEQ_DIV_SIGNED_EN
        checks++;
        if (quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++;
            $display("FAIL div200_7_const: got %0d rem %0d need 28 rem 4", quotient, remainder);
        end
`endif
    endtask

    task automatic test_div_zero();
        check_op("div55_0", 8'd55, 8'd0, 1);
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'd55 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div0_const: got q=%0d r=%0d z=%b need 255 55 1", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_hold();
        logic [7:0] eq, er;
        logic ez;
        int g;
        ref_div(8'd9, 8'd3, eq, er, ez);
        out_ready = 1'b0;
        dividend  = 8'd9;
        divisor   = 8'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin
            tick();
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            dividend = 8'($urandom);
            divisor  = 8'($urandom_range(1, 255));
            tick();
            checks += 4;
            if (out_valid !== 1'b1)  begin errors++; $display("FAIL hold_out_valid[%0d]: got %b need 1", i, out_valid); end
            if (in_ready !== 1'b0)   begin errors++; $display("FAIL hold_in_ready[%0d]: got %b need 0", i, in_ready); end
            if (quotient !== eq)     begin errors++; $display("FAIL hold_quotient[%0d]: got %0d need %0d", i, quotient, eq); end
            if (remainder !== er)    begin errors++; $display("FAIL hold_remainder[%0d]: got %0d need %0d", i, remainder, er); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b need 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL hold_release_ready: got %b need 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        dividend  = 8'd250;
        divisor   = 8'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 5;
        if (in_ready !== 1'b1)    begin errors++; $display("FAIL midrst_in_ready: got %b need 1", in_ready); end
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL midrst_out_valid: got %b need 0", out_valid); end
        if (quotient !== 8'd0)    begin errors++; $display("FAIL midrst_quotient: got %0d need 0", quotient); end
        if (remainder !== 8'd0)   begin errors++; $display("FAIL midrst_remainder: got %0d need 0", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dbz: got %b need 0", div_by_zero); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost[%0d]: out_valid=%b need 0", i, out_valid); end
        end
        check_op("div250_3", 8'd250, 8'd3, 9);
    endtask

    task automatic test_corners();
        check_op("div0_5", 8'd0, 8'd5, 9);
        check_op("div255_1", 8'd255, 8'd1, 9);
        check_op("div5_200", 8'd5, 8'd200, 9);
        check_op("div255_255", 8'd255, 8'd255, 9);
        check_op("div128_255", 8'd128, 8'd255, 9);
        check_op("div0_0", 8'd0, 8'd0, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, q, r, eq, er;
        logic z, ez;
        int lat, prev_acc;
        prev_acc = -1;
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            do_op(a, b, q, r, z, lat);
            ref_div(a, b, eq, er, ez);
            checks += 3;
            if (q !== eq || r !== er || z !== ez) begin
                errors++;
                $display("FAIL b2b_result: %0d/%0d got q=%0d r=%0d z=%b need q=%0d r=%0d z=%b",
                         a, b, q, r, z, eq, er, ez);
            end
`ifndef SEQ_DIV_SIGNED_EN
            if ((int'(q) * int'(b) + int'(r)) != int'(a) || r >= b) begin
                errors++;
                $display("FAIL b2b_invariant: %0d/%0d got q=%0d r=%0d", a, b, q, r);
            end
`else
            if (r === 8'd0 && z !== 1'b0) begin
                errors++;
                $display("FAIL b2b_dbz_flag: %0d/%0d got z=%b need 0", a, b, z);
            end
`endif
            if (prev_acc >= 0 && (acc_cyc - prev_acc) != 10) begin
                errors++;
                $display("FAIL b2b_interval: got %0d cycles need 10", acc_cyc - prev_acc);
            end
            prev_acc = acc_cyc;
        end
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] q, r;
        logic z;
        int lat;
        logic [7:0] ta [4] = '{8'hF9, 8'd7,  8'h80, 8'h80};
        logic [7:0] tb [4] = '{8'd2,  8'hFE, 8'hFF, 8'd1};
        logic [7:0] tq [4] = '{8'hFD, 8'hFD, 8'h80, 8'h80};
        logic [7:0] tr [4] = '{8'hFF, 8'd1,  8'd0,  8'd0};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], q, r, z, lat);
            checks += 3;
            if (q !== tq[i]) begin errors++; $display("FAIL signed_quotient[%0d]: got %0d need %0d", i, $signed(q), $signed(tq[i])); end
            if (r !== tr[i]) begin errors++; $display("FAIL signed_remainder[%0d]: got %0d need %0d", i, $signed(r), $signed(tr[i])); end
            if (z !== 1'b0)  begin errors++; $display("FAIL signed_dbz[%0d]: got %b need 0", i, z); end
        end
        check_op("sdiv_m5_0", 8'hFB, 8'd0, 1);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        test_reset();
        test_basic();
        test_div_zero();
        test_hold();
        test_reset_mid();
        test_corners();
`ifdef SEQ_DIV_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
